// File: rtl/bounded_updown_counter_pkg.sv
// Shared types for the bounded up/down counter.
// FSM states, step direction and the wrap/saturate mode constants.
package bounded_updown_counter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP_ACK   = 2'd1,
    DOWN_ACK = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam bit WRAP_MODE = 1'b1;
  localparam bit SAT_MODE  = 1'b0;

endpackage

// File: rtl/bounded_updown_counter_step_unit.sv
// Combinational step: applies +/-step against [MIN_VAL,MAX_VAL]
// with wrap or saturate, and flags crossings of either bound.
module bounded_updown_counter_step_unit
  import bounded_updown_counter_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int STEP_W  = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2**SIZE-1,
  parameter bit WRAP    = WRAP_MODE
) (
  input  logic [SIZE-1:0]   i_count,
  input  logic [STEP_W-1:0] i_step,
  input  dir_t              i_dir,
  output logic [SIZE-1:0]   o_next,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam int W = SIZE + 1;
  localparam logic [W-1:0] MINW = W'(MIN_VAL);
  localparam logic [W-1:0] MAXW = W'(MAX_VAL);
  localparam logic [W-1:0] RNG  = W'(MAX_VAL - MIN_VAL + 1);

  logic [W-1:0] w_cnt;
  logic [W-1:0] w_step;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_head;
  logic [W-1:0] w_res;

  assign w_cnt  = {1'b0, i_count};
  assign w_step = W'(i_step);
  assign w_sum  = w_cnt + w_step;
  // room below the count; comparing against it avoids any borrow
  assign w_head = w_cnt - MINW;

  always_comb begin
    w_res = w_cnt;
    o_ovf = 1'b0;
    o_unf = 1'b0;
    if (i_dir == DIR_UP) begin
      if (w_sum > MAXW) begin
        o_ovf = 1'b1;
        w_res = (WRAP == WRAP_MODE) ? w_sum - RNG : MAXW;
      end else begin
        w_res = w_sum;
      end
    end else begin
      if (w_step > w_head) begin
        o_unf = 1'b1;
        w_res = (WRAP == WRAP_MODE) ? w_cnt + RNG - w_step : MINW;
      end else begin
        w_res = w_cnt - w_step;
      end
    end
  end

  assign o_next = SIZE'(w_res);

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with 4-phase req/ack handshake,
// parallel load with clamp, terminal flags and ovf/unf pulses.
module bounded_updown_counter
  import bounded_updown_counter_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int STEP_W    = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 2**SIZE-1,
  parameter int RESET_VAL = MIN_VAL,
  parameter bit WRAP      = WRAP_MODE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              up,
  input  logic              down,
  input  logic              load,
  input  logic [SIZE-1:0]   data,
  input  logic [STEP_W-1:0] step,
  output logic              upAck,
  output logic              downAck,
  output logic [SIZE-1:0]   counter,
  output logic              atMax,
  output logic              atMin,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [SIZE-1:0] MINS = SIZE'(MIN_VAL);
  localparam logic [SIZE-1:0] MAXS = SIZE'(MAX_VAL);
  localparam logic [SIZE-1:0] RSTS = SIZE'(RESET_VAL);

  state_t          r_state;
  logic [SIZE-1:0] r_count;
  logic            r_up_ack;
  logic            r_dn_ack;
  logic            r_ovf;
  logic            r_unf;

  dir_t            w_dir;
  logic [SIZE-1:0] w_next;
  logic            w_ovf;
  logic            w_unf;
  logic [SIZE-1:0] w_clamp;

  assign w_dir = up ? DIR_UP : DIR_DOWN;

  bounded_updown_counter_step_unit #(
    .SIZE    (SIZE),
    .STEP_W  (STEP_W),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .WRAP    (WRAP)
  ) u_step (
    .i_count (r_count),
    .i_step  (step),
    .i_dir   (w_dir),
    .o_next  (w_next),
    .o_ovf   (w_ovf),
    .o_unf   (w_unf)
  );

  assign w_clamp = (data < MINS) ? MINS :
                   (data > MAXS) ? MAXS : data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= RSTS;
      r_up_ack <= 1'b0;
      r_dn_ack <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (load) begin
        // state held: a pending request is taken next cycle
        r_count <= w_clamp;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (up) begin
              r_count  <= w_next;
              r_ovf    <= w_ovf;
              r_state  <= UP_ACK;
              r_up_ack <= 1'b1;
            end else if (down) begin
              r_count  <= w_next;
              r_unf    <= w_unf;
              r_state  <= DOWN_ACK;
              r_dn_ack <= 1'b1;
            end
          end
          UP_ACK: begin
            if (!up) begin
              r_state  <= IDLE;
              r_up_ack <= 1'b0;
            end
          end
          DOWN_ACK: begin
            if (!down) begin
              r_state  <= IDLE;
              r_dn_ack <= 1'b0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_up_ack <= 1'b0;
            r_dn_ack <= 1'b0;
          end
        endcase
      end
    end
  end

  assign counter   = r_count;
  assign upAck     = r_up_ack;
  assign downAck   = r_dn_ack;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign atMax     = (r_count == MAXS);
  assign atMin     = (r_count == MINS);

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed bench: a wrapping and a saturating counter share one
// stimulus stream, MIN=10, MAX=20, RESET=10, SIZE=8, STEP_W=4.
module tb_bounded_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b0;
  logic       dn = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] data = 8'd0;
  logic [3:0] step = 4'd0;

  logic [7:0] cw, cs;
  logic uaw, uas, daw, das;
  logic maxw, maxs, minw, mins;
  logic ovw, ovs, unw, uns;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bounded_updown_counter #(
    .SIZE(8), .STEP_W(4), .MIN_VAL(10), .MAX_VAL(20),
    .RESET_VAL(10), .WRAP(1'b1)
  ) dut_w (
    .clock(clk), .reset(rst), .up(up), .down(dn), .load(ld),
    .data(data), .step(step), .upAck(uaw), .downAck(daw),
    .counter(cw), .atMax(maxw), .atMin(minw),
    .overflow(ovw), .underflow(unw)
  );

  bounded_updown_counter #(
    .SIZE(8), .STEP_W(4), .MIN_VAL(10), .MAX_VAL(20),
    .RESET_VAL(10), .WRAP(1'b0)
  ) dut_s (
    .clock(clk), .reset(rst), .up(up), .down(dn), .load(ld),
    .data(data), .step(step), .upAck(uas), .downAck(das),
    .counter(cs), .atMax(maxs), .atMin(mins),
    .overflow(ovs), .underflow(uns)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    ld = 1'b1;
    data = v;
    tick();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (cw !== 8'd10) begin bad++; $display("FAIL reset cnt_w got=%0d exp=10", cw); end
    total++; if (cs !== 8'd10) begin bad++; $display("FAIL reset cnt_s got=%0d exp=10", cs); end
    total++; if ({uaw, daw, ovw, unw} !== 4'b0) begin bad++; $display("FAIL reset flags_w got=%b exp=0000", {uaw, daw, ovw, unw}); end
    total++; if ({minw, maxw} !== 2'b10) begin bad++; $display("FAIL reset minmax got=%b exp=10", {minw, maxw}); end
  endtask

  task automatic test_up_hold();
    step = 4'd3;
    up = 1'b1;
    tick();
    total++; if (cw !== 8'd13 || uaw !== 1'b1) begin bad++; $display("FAIL up_first got=%0d/%b exp=13/1", cw, uaw); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (cw !== 8'd13 || uaw !== 1'b1) begin bad++; $display("FAIL up_hold%0d got=%0d/%b exp=13/1", i, cw, uaw); end
    end
    up = 1'b0;
    tick();
    total++; if (uaw !== 1'b0 || cw !== 8'd13) begin bad++; $display("FAIL up_release got=%0d/%b exp=13/0", cw, uaw); end
    up = 1'b1;
    tick();
    total++; if (cw !== 8'd16 || uaw !== 1'b1) begin bad++; $display("FAIL up_again got=%0d/%b exp=16/1", cw, uaw); end
    up = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    do_load(8'd19);
    total++; if (cw !== 8'd19 || cs !== 8'd19) begin bad++; $display("FAIL load19 got=%0d/%0d exp=19/19", cw, cs); end
    step = 4'd3;
    up = 1'b1;
    tick();
    total++; if (cw !== 8'd11 || ovw !== 1'b1 || maxw !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%0d/%b/%b exp=11/1/0", cw, ovw, maxw); end
    total++; if (cs !== 8'd20 || ovs !== 1'b1 || maxs !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0d/%b/%b exp=20/1/1", cs, ovs, maxs); end
    tick();
    total++; if (ovw !== 1'b0 || ovs !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b%b exp=00", ovw, ovs); end
    up = 1'b0;
    tick();
    do_load(8'd18);
    step = 4'd5;
    up = 1'b1;
    tick();
    total++; if (cs !== 8'd20 || ovs !== 1'b1 || cw !== 8'd12) begin bad++; $display("FAIL sat18 got=%0d/%b/%0d exp=20/1/12", cs, ovs, cw); end
    up = 1'b0;
    tick();
    up = 1'b1;
    tick();
    total++; if (cs !== 8'd20 || uas !== 1'b1 || ovs !== 1'b1) begin bad++; $display("FAIL sat_hold got=%0d/%b/%b exp=20/1/1", cs, uas, ovs); end
    total++; if (cw !== 8'd17) begin bad++; $display("FAIL wrap12p5 got=%0d exp=17", cw); end
    up = 1'b0;
    tick();
  endtask

  task automatic test_underflow();
    do_load(8'd10);
    step = 4'd1;
    dn = 1'b1;
    tick();
    total++; if (cw !== 8'd20 || unw !== 1'b1 || daw !== 1'b1) begin bad++; $display("FAIL wrap_unf got=%0d/%b/%b exp=20/1/1", cw, unw, daw); end
    total++; if (cs !== 8'd10 || uns !== 1'b1 || mins !== 1'b1) begin bad++; $display("FAIL sat_unf got=%0d/%b/%b exp=10/1/1", cs, uns, mins); end
    dn = 1'b0;
    tick();
    total++; if (unw !== 1'b0 || daw !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b/%b exp=0/0", unw, daw); end
  endtask

  task automatic test_both_and_clamp();
    do_load(8'd12);
    step = 4'd2;
    up = 1'b1;
    dn = 1'b1;
    tick();
    total++; if (cw !== 8'd14 || uaw !== 1'b1 || daw !== 1'b0) begin bad++; $display("FAIL both got=%0d/%b/%b exp=14/1/0", cw, uaw, daw); end
    up = 1'b0;
    dn = 1'b0;
    tick();
    do_load(8'd250);
    total++; if (cw !== 8'd20 || maxw !== 1'b1) begin bad++; $display("FAIL clamp_hi got=%0d exp=20", cw); end
    do_load(8'd3);
    total++; if (cw !== 8'd10 || minw !== 1'b1) begin bad++; $display("FAIL clamp_lo got=%0d exp=10", cw); end
  endtask

  task automatic test_step_zero();
    do_load(8'd20);
    step = 4'd0;
    up = 1'b1;
    tick();
    total++; if (cs !== 8'd20 || uas !== 1'b1 || ovs !== 1'b0) begin bad++; $display("FAIL step0 got=%0d/%b/%b exp=20/1/0", cs, uas, ovs); end
    total++; if (cw !== 8'd20 || ovw !== 1'b0) begin bad++; $display("FAIL step0_w got=%0d/%b exp=20/0", cw, ovw); end
    up = 1'b0;
    tick();
  endtask

  task automatic test_load_pending();
    step = 4'd2;
    up = 1'b1;
    ld = 1'b1;
    data = 8'd15;
    tick();
    ld = 1'b0;
    total++; if (cw !== 8'd15 || uaw !== 1'b0 || ovw !== 1'b0) begin bad++; $display("FAIL load_prio got=%0d/%b/%b exp=15/0/0", cw, uaw, ovw); end
    tick();
    total++; if (cw !== 8'd17 || uaw !== 1'b1) begin bad++; $display("FAIL pending got=%0d/%b exp=17/1", cw, uaw); end
    up = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_load(8'd15);
    step = 4'd1;
    dn = 1'b1;
    tick();
    total++; if (cw !== 8'd14 || daw !== 1'b1) begin bad++; $display("FAIL mid_down got=%0d/%b exp=14/1", cw, daw); end
    tick();
    rst = 1'b1;
    tick();
    total++; if (cw !== 8'd10 || daw !== 1'b0 || das !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b/%b exp=10/0/0", cw, daw, das); end
    rst = 1'b0;
    tick();
    total++; if (cw !== 8'd20 || unw !== 1'b1 || daw !== 1'b1) begin bad++; $display("FAIL reaccept got=%0d/%b/%b exp=20/1/1", cw, unw, daw); end
    total++; if (cs !== 8'd10 || uns !== 1'b1) begin bad++; $display("FAIL reaccept_s got=%0d/%b exp=10/1", cs, uns); end
    dn = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_up_hold();
    test_overflow();
    test_underflow();
    test_both_and_clamp();
    test_step_zero();
    test_load_pending();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
